// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: FILL, RUN, BOUNCE and BLINK patterns driven by a
// programmable prescaler tick, a speed divider and a pause control.
module led_pattern_gen #(
    parameter int LED_W    = 8,
    parameter int TICK_MAX = 49_999_999,
    parameter int CNT_W    = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             pause,
    input  logic [1:0]       speed,
    output logic [LED_W-1:0] led,
    output logic             step_pulse
);

    typedef enum logic [1:0] {
        FILL   = 2'b00,
        RUN    = 2'b01,
        BOUNCE = 2'b10,
        BLINK  = 2'b11
    } mode_t;

    localparam logic [LED_W-1:0] ALL_ONES = '1;
    localparam logic [LED_W-1:0] LSB_ONE  = LED_W'(1);
    localparam logic [LED_W-1:0] MSB_ONE  = LSB_ONE << (LED_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       div_reg;
    mode_t            mode_q;
    logic             bdir_reg;

    logic             tick;
    logic             step;
    logic             led_onehot;
    logic [LED_W-1:0] bounce_shift;
    logic [LED_W-1:0] led_next;
    logic             bdir_next;

    function automatic logic [LED_W-1:0] init_pattern(input logic [1:0] m, input logic d);
        logic [LED_W-1:0] p;
        p = '0;
        if (m == RUN)
            p = d ? MSB_ONE : LSB_ONE;
        else if (m == BOUNCE)
            p = LSB_ONE;
        return p;
    endfunction

    assign tick       = (cnt_reg == CNT_LAST) && !pause;
    // A divider left above a freshly lowered speed still steps on the next tick.
    assign step       = tick && (div_reg >= speed);
    assign led_onehot = (led != '0) && ((led & (led - LSB_ONE)) == '0);
    assign bounce_shift = bdir_reg ? (led >> 1) : (led << 1);

    always_comb begin
        led_next  = led;
        bdir_next = bdir_reg;
        case (mode_q)
            FILL: begin
                if (led == ALL_ONES)
                    led_next = '0;
                else if (!dir)
                    led_next = {led[LED_W-2:0], 1'b1};
                else
                    led_next = {1'b1, led[LED_W-1:1]};
            end
            RUN: begin
                if (led == '0)
                    led_next = init_pattern(RUN, dir);
                else if (!dir)
                    led_next = {led[LED_W-2:0], led[LED_W-1]};
                else
                    led_next = {led[0], led[LED_W-1:1]};
            end
            BOUNCE: begin
                // Direction flips on the step that lands on an end, so each end shows once.
                if (!led_onehot) begin
                    led_next  = LSB_ONE;
                    bdir_next = 1'b0;
                end else begin
                    led_next = bounce_shift;
                    if (bounce_shift[LED_W-1])
                        bdir_next = 1'b1;
                    else if (bounce_shift[0])
                        bdir_next = 1'b0;
                end
            end
            default: led_next = ~led;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            div_reg    <= '0;
            mode_q     <= FILL;
            bdir_reg   <= 1'b0;
            led        <= '0;
            step_pulse <= 1'b0;
        end else if (mode != mode_q) begin
            // Mode switch restarts the pattern and timing, even while paused.
            mode_q     <= mode_t'(mode);
            led        <= init_pattern(mode, dir);
            cnt_reg    <= '0;
            div_reg    <= '0;
            bdir_reg   <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            if (!pause)
                cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
            if (tick)
                div_reg <= step ? 2'd0 : div_reg + 2'd1;
            step_pulse <= step;
            if (step) begin
                led      <= led_next;
                bdir_reg <= bdir_next;
            end
        end
    end

endmodule
